// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared FSM states, parity modes and frame-length helper for the configurable UART (break states only with UART_TX_BREAK_EN)
package uart_cfg_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK,
    S_BRK_STOP
`endif
  } state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  function automatic int frame_len(input int cpb, input int db, input int par, input int sb);
    return cpb * (1 + db + (par != PAR_NONE ? 1 : 0) + sb);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter with synchronous clear and a one-cycle tick on the last cycle of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_tick = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clear || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with valid/ready holding register; define UART_TX_BREAK_EN to add i_Break line-break generation
module uart_tx_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_Break,
`endif
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);
  state_t state, state_n;
  logic [DATA_BITS-1:0] hold, shift, shift_n;
  logic [3:0] bit_cnt, bit_n;
  logic hold_full, par, par_n, load, accept, tick, clear, serial_n, last_stop, last_data;
  assign accept = i_Tx_DV && o_Tx_Ready;
  assign o_Tx_Active = state != S_IDLE;
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(i_Clock),
    .rst(reset),
    .clear(clear),
    .bit_tick(tick)
  );
`ifdef UART_TX_BREAK_EN
  localparam int FRAME = frame_len(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS);
  localparam int BW = $clog2(FRAME);
  logic [BW-1:0] brk_cnt;
  logic brk_done;
  assign brk_done = brk_cnt == BW'(FRAME - 1);
  assign clear = state == S_IDLE || state == S_BREAK;
  assign o_Tx_Ready = !hold_full && !(state == S_BREAK || state == S_BRK_STOP || (state == S_IDLE && i_Break));
  always_ff @(posedge i_Clock or posedge reset)
    if (reset) brk_cnt <= '0;
    else if (state != S_BREAK) brk_cnt <= '0;
    else if (!brk_done) brk_cnt <= brk_cnt + 1'b1;
`else
  assign clear = state == S_IDLE;
  assign o_Tx_Ready = !hold_full;
`endif
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n = bit_cnt;
    par_n = par;
    load = 1'b0;
    o_Tx_Done = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) load = 1'b1;
`ifdef UART_TX_BREAK_EN
        else if (i_Break) state_n = S_BREAK;
`endif
      end
      S_START: if (tick) begin
        state_n = S_DATA;
        bit_n = '0;
      end
      S_DATA: if (tick) begin
        if (last_data) begin
          state_n = PARITY != PAR_NONE ? S_PARITY : S_STOP;
          bit_n = '0;
        end else begin
          shift_n = shift >> 1;
          bit_n = bit_cnt + 1'b1;
        end
      end
      S_PARITY: if (tick) state_n = S_STOP;
      S_STOP: if (tick) begin
        if (last_stop) begin
          o_Tx_Done = 1'b1;
          load = hold_full;
          state_n = S_IDLE;
        end else bit_n = bit_cnt + 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: if (brk_done && !i_Break) begin
        state_n = S_BRK_STOP;
        bit_n = '0;
      end
      S_BRK_STOP: if (tick) begin
        if (last_stop) state_n = S_IDLE;
        else bit_n = bit_cnt + 1'b1;
      end
`endif
      default: state_n = S_IDLE;
    endcase
    // a full holding register at the last stop tick restarts without an idle cycle
    if (load) begin
      state_n = S_START;
      shift_n = hold;
      par_n = ^hold ^ (PARITY == PAR_ODD);
    end
    serial_n = state_n == S_DATA ? shift_n[0] : state_n == S_PARITY ? par_n : state_n != S_START;
`ifdef UART_TX_BREAK_EN
    if (state_n == S_BREAK) serial_n = 1'b0;
`endif
  end
  always_ff @(posedge i_Clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      shift <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      bit_cnt <= '0;
      par <= 1'b0;
      o_Tx_Serial <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_n;
      par <= par_n;
      o_Tx_Serial <= serial_n;
      hold_full <= accept || (hold_full && !load);
      if (accept) hold <= i_Tx_Data;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four configurations of uart_tx_cfg checked cycle by cycle against a frame-queue reference model
module tb_uart_tx_cfg;
  localparam int CPB [4] = '{4, 4, 4, 3};
  localparam int DB [4] = '{8, 8, 5, 9};
  localparam int PAR [4] = '{0, 2, 0, 1};
  localparam int SB [4] = '{1, 1, 2, 2};
  logic clk, rst, brk;
  logic [3:0] dv, rdy, act, ser, dn, acc;
  logic [8:0] data [4];
  logic [2:0] mem [4][256];
  int wr [4], rd [4], start_at [4];
  int t, n_cmp, n_err;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  uart_tx_cfg #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0])) d0 (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Data(data[0][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_Break(brk),
`endif
    .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(dn[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1])) d1 (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Data(data[1][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_Break(1'b0),
`endif
    .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(dn[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2])) d2 (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Data(data[2][4:0]),
`ifdef UART_TX_BREAK_EN
    .i_Break(1'b0),
`endif
    .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(dn[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(SB[3])) d3 (
    .i_Clock(clk), .reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Data(data[3]),
`ifdef UART_TX_BREAK_EN
    .i_Break(1'b0),
`endif
    .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(dn[3]));
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask
  task automatic push(input int i, input logic [2:0] e);
    mem[i][wr[i] % 256] = e;
    wr[i]++;
  endtask
  // expected line per cycle: {active, done, serial}
  task automatic push_frame(input int i, input logic [8:0] d);
    int nb, ones;
    logic v, p;
    ones = $countones(d);
    p = PAR[i] == 1 ? (ones % 2 == 0) : (ones % 2 == 1);
    nb = 1 + DB[i] + (PAR[i] != 0 ? 1 : 0) + SB[i];
    for (int b = 0; b < nb; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= DB[i]) v = d[b-1];
      else if (PAR[i] != 0 && b == DB[i] + 1) v = p;
      else v = 1'b1;
      for (int c = 0; c < CPB[i]; c++) push(i, {1'b1, b == nb - 1 && c == CPB[i] - 1, v});
    end
  endtask
  task automatic tick();
    logic [2:0] e;
    for (int i = 0; i < 4; i++) acc[i] = dv[i] && rdy[i];
    @(posedge clk);
    t++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        if (wr[i] == rd[i]) push(i, 3'b001);
        start_at[i] = t + wr[i] - rd[i];
        push_frame(i, data[i]);
      end
      e = 3'b001;
      if (wr[i] != rd[i]) begin
        e = mem[i][rd[i] % 256];
        rd[i]++;
      end
      check($sformatf("d%0d serial", i), ser[i], e[0]);
      check($sformatf("d%0d done", i), dn[i], e[1]);
      check($sformatf("d%0d active", i), act[i], e[2]);
      check($sformatf("d%0d ready", i), rdy[i], t >= start_at[i]);
    end
  endtask
  function automatic int busy();
    int b = 0;
    for (int i = 0; i < 4; i++) if (wr[i] != rd[i] || start_at[i] > t) b = 1;
    return b;
  endfunction
  task automatic wait_idle();
    int n = 0;
    dv = '0;
    while (busy() != 0 && n < 400) begin
      tick();
      n++;
    end
    check("idle_timeout", busy(), 0);
  endtask
  task automatic set_all(input int val);
    for (int i = 0; i < 4; i++) data[i] = 9'(val & ((1 << DB[i]) - 1));
  endtask
  initial begin
    int sent [4];
`ifdef UART_TX_BREAK_EN
    logic s_log [64], r_log [64], a_log [64];
    int nlow, rise;
`endif
    t = 0; n_cmp = 0; n_err = 0;
    rst = 1'b1; brk = 1'b0; dv = '0;
    set_all(0);
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0; rd[i] = 0; start_at[i] = 0; sent[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d rst serial", i), ser[i], 1);
      check($sformatf("d%0d rst ready", i), rdy[i], 1);
      check($sformatf("d%0d rst active", i), act[i], 0);
      check($sformatf("d%0d rst done", i), dn[i], 0);
    end
    rst = 1'b0;
    repeat (3) tick();
    set_all(32'h61);
    data[2] = 9'h15;
    dv = 4'hF;
    tick();
    dv = '0;
    wait_idle();
    for (int n = 0; n < 400 && (sent[0] < 2 || sent[1] < 2 || sent[2] < 2 || sent[3] < 2); n++) begin
      for (int i = 0; i < 4; i++) begin
        dv[i] = sent[i] < 2;
        data[i] = 9'((sent[i] == 0 ? 32'hA5 : 32'h3C) & ((1 << DB[i]) - 1));
      end
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
    end
    check("b2b_sent", sent[0] + sent[1] + sent[2] + sent[3], 8);
    wait_idle();
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 4; i++) begin
        dv[i] = $urandom_range(0, 2) != 0;
        data[i] = 9'($urandom_range(0, (1 << DB[i]) - 1));
      end
      tick();
    end
    wait_idle();
    set_all(0);
    dv = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) data[i] = 9'($urandom_range(0, (1 << DB[i]) - 1));
    repeat (3) tick();
    dv = '0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d async serial", i), ser[i], 1);
      check($sformatf("d%0d async ready", i), rdy[i], 1);
      check($sformatf("d%0d async active", i), act[i], 0);
      check($sformatf("d%0d async done", i), dn[i], 0);
    end
    @(posedge clk);
    t++;
    @(posedge clk);
    t++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd[i] = wr[i];
      start_at[i] = t;
    end
    repeat (60) tick();
`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    for (int j = 0; j < 64; j++) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (j == 19) brk = 1'b0;
      s_log[j] = ser[0];
      r_log[j] = rdy[0];
      a_log[j] = act[0];
    end
    nlow = 0;
    rise = -1;
    for (int j = 0; j < 64; j++) begin
      if (!s_log[j]) nlow++;
      if (rise < 0 && r_log[j]) rise = j;
    end
    check("brk_low_cycles", nlow, 40);
    check("brk_first_low", s_log[0], 0);
    check("brk_release_high", s_log[40], 1);
    check("brk_ready_rise", rise, 44);
    check("brk_active_end", a_log[43], 1);
    check("brk_active_off", a_log[44], 0);
    for (int i = 0; i < 4; i++) start_at[i] = t;
    repeat (10) tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Adds configurable data width, parity mode, stop-bit count and baud divisor. Replaces the bare strobe input with a valid/ready handshake backed by a one-entry holding register, so frames go out back-to-back with no idle gap. Sits between the accelerator's result path and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, i_Clock cycles per bit time (min 2).
DATA_BITS, 8, payload bits per frame, legal 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame, legal 1 or 2.

Ports:
i_Clock  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
i_Tx_DV  in  1  payload valid.
i_Tx_Data  in  DATA_BITS  payload, sent LSB first.
o_Tx_Ready  out  1  holding register empty; word accepted when i_Tx_DV && o_Tx_Ready.
o_Tx_Active  out  1  frame on the line.
o_Tx_Serial  out  1  serial line, idle high.
o_Tx_Done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset values: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0. Holding register, shifter, bit counter and baud counter are cleared.
- Reset mid-frame: the line returns high asynchronously. The frame in progress and any held word are discarded and never resumed.
- Frame format: start(0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits(1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length in cycles: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
- Parity is computed over the accepted data. Odd mode: total ones across data+parity is odd. Even mode: total is even.
- Handshake:
  - On acceptance at edge k, the word enters the holding register and o_Tx_Ready drops after edge k.
  - If the FSM is IDLE, the shifter loads at edge k+1 and o_Tx_Serial goes low after edge k+1. Latency is 1 cycle.
  - o_Tx_Ready rises again in the cycle after the holding register transfers to the shifter.
  - A word can be accepted while a frame is in flight.
  - i_Tx_Data is sampled only on acceptance.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE or START. Each state advances on a baud-counter terminal count.
  - DATA iterates DATA_BITS times.
  - STOP iterates STOP_BITS times.
- Frame end / back-to-back:
  - In the last cycle of the final stop bit, o_Tx_Done=1 for one cycle.
  - If the holding register is full at that point, the next edge enters START directly, giving zero idle cycles between frames.
  - Otherwise the FSM returns to IDLE.
- o_Tx_Active is high from the first START cycle through the last STOP cycle inclusive. It stays high across back-to-back frames.
- Simultaneous events: acceptance in the same cycle as a holding-to-shifter transfer is not possible, because Ready is low then.
- Baud counter: width is clog2(CLKS_PER_BIT). It reloads to 0 on every state or bit transition.
- o_Tx_Serial is registered (glitch-free).

Optional Feature:
UART_TX_BREAK_EN:
- Defined:
  - Adds input i_Break (1 bit).
  - When i_Break=1 while in IDLE with the holding register empty, the FSM enters BREAK and drives o_Tx_Serial=0.
  - o_Tx_Ready=0 and o_Tx_Active=1 for as long as i_Break stays high, with a minimum of one full frame length.
  - After release, the line is held high for STOP_BITS bit times, then the FSM returns to IDLE. No o_Tx_Done pulse is generated.
  - i_Break is ignored mid-frame until the next IDLE.
- Undefined: the port is absent and the BREAK state does not exist.

Decomposition:
- Package uart_cfg_pkg holds:
  - the FSM state enumeration;
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a frame-length function used by RTL and bench.
- Sub-module uart_baud_gen(CLKS_PER_BIT): counter with clear input and one-cycle bit_tick output. It is reusable by the future RX.

Test Plan:
1. CLKS_PER_BIT=4, defaults. Send 8'h61 -> line shows 0,1,0,0,0,0,1,1,0,1, each bit 4 cycles. Start goes low 1 cycle after acceptance. o_Tx_Done pulses once, at cycle 40 of the frame.
2. PARITY=2, DATA_BITS=8, 8'h61 -> parity bit 1. PARITY=1 -> parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
3. Back-to-back: hold i_Tx_DV=1 with 8'hA5 then 8'h3C. Second word is accepted during the first frame. Its start bit follows the first frame's final stop bit with zero idle cycles. o_Tx_Active stays high; two Done pulses are 40 cycles apart.
4. DATA_BITS=5, STOP_BITS=2, send 5'h15 -> 0,1,0,1,0,1,1,1. Frame is 32 cycles.
5. Assert reset at mid-DATA -> o_Tx_Serial=1 immediately (before the next edge). Ready=1, Active=0, and no Done pulse. Held word is dropped; after deassert the line stays idle.
6. With UART_TX_BREAK_EN: i_Break high for 20 cycles at CLKS_PER_BIT=4 -> line low 40 cycles (min frame), then high 4 cycles before Ready=1.
